// File: rtl/nf10_tx_pkt_buffer_pkg.sv
// Shared definitions for the egress store-and-forward packet buffer:
// write-side state encoding, default widths and the RAM entry width helper.
package nf10_tx_pkt_buffer_pkg;

    typedef enum logic [0:0] {
        WR_PKT  = 1'b0,
        WR_DROP = 1'b1
    } wr_state_t;

    localparam int DEF_AXIS_DATA_WIDTH  = 64;
    localparam int DEF_AXIS_TUSER_WIDTH = 128;
    localparam int DEF_ADDR_WIDTH       = 9;
    localparam int DEF_META_ADDR_WIDTH  = 5;

    // Data RAM entry is {tlast, tstrb, tdata}.
    function automatic int ram_entry_width(input int data_width);
        return data_width + (data_width / 8) + 1;
    endfunction

endpackage

// File: rtl/nf10_sdp_ram.sv
// Simple dual-port RAM: one synchronous write port and one registered read
// port whose output holds its last value while rd_en is low.
module nf10_sdp_ram #(
    parameter int WIDTH      = 73,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem_r [2**ADDR_WIDTH];

    // Write port: storage array carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/nf10_tx_pkt_buffer.sv
// Store-and-forward packet buffer for the 64-bit egress path: a packet is
// released to the MAC only once fully stored; packets that do not fit are dropped.
module nf10_tx_pkt_buffer
    import nf10_tx_pkt_buffer_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = DEF_AXIS_DATA_WIDTH,
    parameter int C_AXIS_TUSER_WIDTH = DEF_AXIS_TUSER_WIDTH,
    parameter int C_ADDR_WIDTH       = DEF_ADDR_WIDTH,
    parameter int C_META_ADDR_WIDTH  = DEF_META_ADDR_WIDTH
) (
    input  logic                            axi_aclk,
    input  logic                            axi_resetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic [31:0]                     drop_count
);

    localparam int DW      = C_AXIS_DATA_WIDTH;
    localparam int SW      = C_AXIS_DATA_WIDTH / 8;
    localparam int TW      = C_AXIS_TUSER_WIDTH;
    localparam int AW      = C_ADDR_WIDTH;
    localparam int MAW     = C_META_ADDR_WIDTH;
    localparam int ENTRY_W = ram_entry_width(C_AXIS_DATA_WIDTH);

    localparam logic [AW:0]    PTR_ONE  = (AW+1)'(1'b1);
    localparam logic [MAW:0]   MPTR_ONE = (MAW+1)'(1'b1);
    localparam logic [MAW-1:0] MIDX_ONE = MAW'(1'b1);

    wr_state_t wr_state_r;
    wr_state_t wr_state_s;

    logic [AW:0]     wr_ptr_r;
    logic [AW:0]     commit_ptr_r;
    logic [AW:0]     rd_ptr_r;
    logic [MAW:0]    meta_wr_ptr_r;
    logic [MAW:0]    meta_pop_ptr_r;
    logic [MAW-1:0]  meta_rd_idx_r;
    logic            sop_r;
    logic [TW-1:0]   tuser_cap_r;
    logic [31:0]     drop_count_r;
    logic            rd_started_r;
    logic            pf_valid_r;
    logic            out_valid_r;
    logic            out_last_r;
    logic [DW-1:0]   out_data_r;
    logic [SW-1:0]   out_strb_r;
    logic [TW-1:0]   out_tuser_r;

    logic               s_ready_s;
    logic               accept_s;
    logic               ram_full_s;
    logic               meta_full_s;
    logic               wr_en_s;
    logic               commit_s;
    logic               drop_s;
    logic [TW-1:0]      meta_wdata_s;
    logic [ENTRY_W-1:0] ram_wdata_s;
    logic [ENTRY_W-1:0] ram_q_s;
    logic [TW-1:0]      meta_q_s;
    logic               data_avail_s;
    logic               out_free_s;
    logic               load_out_s;
    logic               pf_free_s;
    logic               rd_en_s;
    logic               rd_sop_s;
    logic               meta_rd_en_s;
    logic               pop_s;

    assign ram_full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                         (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign meta_full_s = (meta_wr_ptr_r[MAW] != meta_pop_ptr_r[MAW]) &&
                         (meta_wr_ptr_r[MAW-1:0] == meta_pop_ptr_r[MAW-1:0]);

    // Only a packet start can be held off, and only when no metadata slot is free.
    assign s_ready_s    = axi_resetn && !(sop_r && meta_full_s);
    assign accept_s     = s_axis_tvalid && s_ready_s;
    assign ram_wdata_s  = {s_axis_tlast, s_axis_tstrb, s_axis_tdata};
    assign meta_wdata_s = sop_r ? s_axis_tuser : tuser_cap_r;

    // Write FSM next state and per-beat write/commit/drop decisions.
    always_comb begin
        wr_state_s = wr_state_r;
        wr_en_s    = 1'b0;
        commit_s   = 1'b0;
        drop_s     = 1'b0;
        case (wr_state_r)
            WR_PKT: begin
                if (accept_s) begin
                    if (ram_full_s) begin
                        drop_s = 1'b1;
                        if (s_axis_tlast) begin
                            wr_state_s = WR_PKT;
                        end else begin
                            wr_state_s = WR_DROP;
                        end
                    end else begin
                        wr_en_s  = 1'b1;
                        commit_s = s_axis_tlast;
                    end
                end else begin
                    wr_state_s = WR_PKT;
                end
            end
            WR_DROP: begin
                if (accept_s && s_axis_tlast) begin
                    wr_state_s = WR_PKT;
                end else begin
                    wr_state_s = WR_DROP;
                end
            end
            default: begin
                wr_state_s = WR_PKT;
            end
        endcase
    end

    // Write FSM state register.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            wr_state_r <= WR_PKT;
        end else begin
            wr_state_r <= wr_state_s;
        end
    end

    // Write/commit pointers, metadata push, first-beat capture and drop counter.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            wr_ptr_r      <= '0;
            commit_ptr_r  <= '0;
            meta_wr_ptr_r <= '0;
            sop_r         <= 1'b1;
            tuser_cap_r   <= '0;
            drop_count_r  <= 32'd0;
        end else begin
            // A drop rewinds over the partial packet so none of it becomes visible.
            if (drop_s) begin
                wr_ptr_r <= commit_ptr_r;
            end else if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (commit_s) begin
                commit_ptr_r  <= wr_ptr_r + PTR_ONE;
                meta_wr_ptr_r <= meta_wr_ptr_r + MPTR_ONE;
            end
            if (accept_s) begin
                sop_r <= s_axis_tlast;
            end
            if (accept_s && sop_r) begin
                tuser_cap_r <= s_axis_tuser;
            end
            if (drop_s) begin
                drop_count_r <= drop_count_r + 32'd1;
            end
        end
    end

    // Prefetch stage is the RAM read register; the output register sits behind it.
    assign data_avail_s = (rd_ptr_r != commit_ptr_r);
    assign out_free_s   = !out_valid_r || m_axis_tready;
    assign load_out_s   = pf_valid_r && out_free_s;
    assign pf_free_s    = !pf_valid_r || load_out_s;
    assign rd_en_s      = data_avail_s && pf_free_s;
    // The RAM read register keeps the last beat read, so its tlast tells us whether
    // the next read begins a packet and must also fetch that packet's metadata.
    assign rd_sop_s     = !rd_started_r || ram_q_s[ENTRY_W-1];
    assign meta_rd_en_s = rd_en_s && rd_sop_s;
    assign pop_s        = out_valid_r && m_axis_tready && out_last_r;

    // Read pointers, prefetch valid flag and metadata pop pointer.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            rd_ptr_r       <= '0;
            rd_started_r   <= 1'b0;
            pf_valid_r     <= 1'b0;
            meta_rd_idx_r  <= '0;
            meta_pop_ptr_r <= '0;
        end else begin
            if (rd_en_s) begin
                rd_ptr_r     <= rd_ptr_r + PTR_ONE;
                rd_started_r <= 1'b1;
                pf_valid_r   <= 1'b1;
            end else if (load_out_s) begin
                pf_valid_r <= 1'b0;
            end
            if (meta_rd_en_s) begin
                meta_rd_idx_r <= meta_rd_idx_r + MIDX_ONE;
            end
            if (pop_s) begin
                meta_pop_ptr_r <= meta_pop_ptr_r + MPTR_ONE;
            end
        end
    end

    // Output register; holds while stalled by the MAC.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= '0;
            out_strb_r  <= '0;
            out_tuser_r <= '0;
        end else if (load_out_s) begin
            out_valid_r <= 1'b1;
            out_last_r  <= ram_q_s[ENTRY_W-1];
            out_strb_r  <= ram_q_s[ENTRY_W-2 -: SW];
            out_data_r  <= ram_q_s[DW-1:0];
            out_tuser_r <= meta_q_s;
        end else if (m_axis_tready) begin
            out_valid_r <= 1'b0;
        end
    end

    nf10_sdp_ram #(
        .WIDTH      (ENTRY_W),
        .ADDR_WIDTH (AW)
    ) u_data_ram (
        .clk     (axi_aclk),
        .rst_n   (axi_resetn),
        .wr_en   (wr_en_s),
        .wr_addr (wr_ptr_r[AW-1:0]),
        .wr_data (ram_wdata_s),
        .rd_en   (rd_en_s),
        .rd_addr (rd_ptr_r[AW-1:0]),
        .rd_data (ram_q_s)
    );

    nf10_sdp_ram #(
        .WIDTH      (TW),
        .ADDR_WIDTH (MAW)
    ) u_meta_fifo (
        .clk     (axi_aclk),
        .rst_n   (axi_resetn),
        .wr_en   (commit_s),
        .wr_addr (meta_wr_ptr_r[MAW-1:0]),
        .wr_data (meta_wdata_s),
        .rd_en   (meta_rd_en_s),
        .rd_addr (meta_rd_idx_r),
        .rd_data (meta_q_s)
    );

    assign s_axis_tready = s_ready_s;
    assign m_axis_tvalid = out_valid_r;
    assign m_axis_tlast  = out_last_r;
    assign m_axis_tdata  = out_data_r;
    assign m_axis_tstrb  = out_strb_r;
    assign m_axis_tuser  = out_tuser_r;
    assign drop_count    = drop_count_r;

endmodule

// File: tb/tb_nf10_tx_pkt_buffer.sv
// Directed bench for nf10_tx_pkt_buffer with a 16-beat data RAM and a
// 4-entry metadata FIFO; an output monitor checks every delivered beat.
module tb_nf10_tx_pkt_buffer;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [63:0]   s_tdata;
    logic [7:0]    s_tstrb;
    logic [127:0]  s_tuser;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tlast;
    logic [63:0]   m_tdata;
    logic [7:0]    m_tstrb;
    logic [127:0]  m_tuser;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic [31:0]   drop_count;

    nf10_tx_pkt_buffer #(
        .C_AXIS_DATA_WIDTH  (64),
        .C_AXIS_TUSER_WIDTH (128),
        .C_ADDR_WIDTH       (4),
        .C_META_ADDR_WIDTH  (2)
    ) dut (
        .axi_aclk      (clk),
        .axi_resetn    (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tstrb  (s_tstrb),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tstrb  (m_tstrb),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]  data;
        logic [7:0]   strb;
        logic         last;
        logic [127:0] user;
    } beat_t;

    typedef struct {
        int           len;
        logic [127:0] user;
        int           mode;      // 0: m_tready low, 1: high, 2: random
        bit           deliver;
        logic [31:0]  drops;     // drop_count expected after the packet
    } vec_t;

    beat_t exp_q[$];
    vec_t  vecs[12];
    int    tests = 0;
    int    fails = 0;
    int    mode  = 1;
    bit    mid_pkt = 1'b0;
    int    stalls;
    int    stalls5;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk_beat(input logic [127:0] user, input int i, input int len);
        beat_t b;
        b.data = {user[31:0], 32'(i)};
        b.strb = (i == len - 1) ? 8'h3F : 8'hFF;
        b.last = (i == len - 1);
        b.user = user;
        return b;
    endfunction

    // Sink ready generator.
    initial begin
        m_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mode == 2) m_tready = 1'($urandom_range(0, 1));
            else           m_tready = (mode == 1);
        end
    end

    // Output monitor: handshakes are judged from values stable at the falling edge.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mid_pkt = 1'b0;
            end else begin
                if (mid_pkt) check("no_gap", 128'(m_tvalid), 128'(1'b1));
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL extra_beat: got data %0h expected no beat", m_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("tdata", 128'(m_tdata), 128'(e.data));
                        check("tstrb", 128'(m_tstrb), 128'(e.strb));
                        check("tlast", 128'(m_tlast), 128'(e.last));
                        check("tuser", m_tuser, e.user);
                    end
                    mid_pkt = !m_tlast;
                end
            end
        end
    end

    // Drives one packet; tuser is meaningful on the first beat only.
    task automatic send_pkt(input int len, input logic [127:0] user, input bit deliver, output int nstall);
        beat_t b;
        bit    done;
        nstall = 0;
        for (int i = 0; i < len; i++) begin
            b        = mk_beat(user, i, len);
            s_tdata  = b.data;
            s_tstrb  = b.strb;
            s_tlast  = b.last;
            s_tuser  = (i == 0) ? user : ~user;
            s_tvalid = 1'b1;
            if (deliver) exp_q.push_back(b);
            done = 1'b0;
            while (!done) begin
                @(negedge clk);
                done = s_tready;
                @(posedge clk);
                #1;
                if (!done) begin
                    nstall++;
                    if (nstall > 500) begin
                        tests++;
                        fails++;
                        $display("FAIL send_timeout: got no s_axis_tready expected ready within 500 cycles");
                        done = 1'b1;
                    end
                end
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 128'(exp_q.size()), 128'(0));
        repeat (3) @(posedge clk);
        #1;
        check("idle_tvalid", 128'(m_tvalid), 128'(1'b0));
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = 64'd0;
        s_tstrb  = 8'd0;
        s_tuser  = 128'd0;

        vecs[0]  = '{1,  128'h0000_0000_0000_0000_0000_0000_0000_0101, 2, 1'b1, 32'd0};
        vecs[1]  = '{5,  128'h1111_0000_0000_0000_0000_0000_0000_0202, 2, 1'b1, 32'd0};
        vecs[2]  = '{8,  128'h2222_0000_0000_0000_0000_0000_0000_0303, 2, 1'b1, 32'd0};
        vecs[3]  = '{2,  128'h3333_0000_0000_0000_0000_0000_0000_0404, 2, 1'b1, 32'd0};
        vecs[4]  = '{16, 128'h4444_0000_0000_0000_0000_0000_0000_0505, 2, 1'b1, 32'd0};
        vecs[5]  = '{7,  128'h5555_0000_0000_0000_0000_0000_0000_0606, 2, 1'b1, 32'd0};
        vecs[6]  = '{11, 128'h6666_0000_0000_0000_0000_0000_0000_0707, 2, 1'b1, 32'd0};
        vecs[7]  = '{3,  128'h7777_0000_0000_0000_0000_0000_0000_0808, 2, 1'b1, 32'd0};
        vecs[8]  = '{13, 128'h8888_0000_0000_0000_0000_0000_0000_0909, 2, 1'b1, 32'd0};
        vecs[9]  = '{1,  128'h9999_0000_0000_0000_0000_0000_0000_0A0A, 2, 1'b1, 32'd0};
        vecs[10] = '{20, 128'hAAAA_0000_0000_0000_0000_0000_0000_0B0B, 1, 1'b0, 32'd1};
        vecs[11] = '{4,  128'hBBBB_0000_0000_0000_0000_0000_0000_0C0C, 1, 1'b1, 32'd1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 128'(m_tvalid), 128'(1'b0));
        check("rst_tlast", 128'(m_tlast), 128'(1'b0));
        check("rst_tdata", 128'(m_tdata), 128'(0));
        check("rst_tuser", m_tuser, 128'(0));
        check("rst_s_tready", 128'(s_tready), 128'(1'b0));
        check("rst_drop_count", 128'(drop_count), 128'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_s_tready", 128'(s_tready), 128'(1'b1));

        // Latency: tlast accepted at edge N, first output beat after edge N+2.
        mode = 1;
        send_pkt(3, 128'hA5, 1'b1, stalls);
        check("lat_n0_tvalid", 128'(m_tvalid), 128'(1'b0));
        @(posedge clk);
        #1;
        check("lat_n1_tvalid", 128'(m_tvalid), 128'(1'b0));
        @(posedge clk);
        #1;
        check("lat_n2_tvalid", 128'(m_tvalid), 128'(1'b1));
        check("lat_n2_tdata", 128'(m_tdata), 128'(64'h0000_00A5_0000_0000));
        check("lat_n2_tuser", m_tuser, 128'hA5);
        wait_drain("lat_drain");

        // Table: varied lengths and sink behaviour, including an oversize drop.
        for (int v = 0; v < 12; v++) begin
            mode = vecs[v].mode;
            send_pkt(vecs[v].len, vecs[v].user, vecs[v].deliver, stalls);
            check("vec_s_tready_stalls", 128'(stalls), 128'(0));
            wait_drain("vec_drain");
            check("vec_drop_count", 128'(drop_count), 128'(vecs[v].drops));
        end

        // Exactly-full packet with the sink stalled.
        mode = 0;
        send_pkt(16, 128'hF0F0, 1'b1, stalls);
        check("full_stalls", 128'(stalls), 128'(0));
        repeat (4) @(posedge clk);
        #1;
        check("full_tvalid_held", 128'(m_tvalid), 128'(1'b1));
        check("full_tdata_held", 128'(m_tdata), 128'(64'h0000_F0F0_0000_0000));
        check("full_queued", 128'(exp_q.size()), 128'(16));
        check("full_drop_count", 128'(drop_count), 128'(1));
        mode = 1;
        wait_drain("full_drain");

        // Metadata FIFO full blocks the fifth packet start.
        mode = 0;
        for (int k = 0; k < 4; k++) begin
            send_pkt(1, 128'h50 + 128'(k), 1'b1, stalls);
            check("meta_stalls", 128'(stalls), 128'(0));
        end
        check("meta_full_s_tready", 128'(s_tready), 128'(1'b0));
        fork
            send_pkt(1, 128'h54, 1'b1, stalls5);
            begin
                repeat (6) @(posedge clk);
                #1;
                check("meta_still_blocked", 128'(s_tready), 128'(1'b0));
                mode = 1;
            end
        join
        check("meta_sop_blocked", 128'(stalls5 >= 6), 128'(1'b1));
        wait_drain("meta_drain");

        // Reset in the middle of an outgoing packet.
        mode = 1;
        send_pkt(4, 128'h66, 1'b1, stalls);
        n = 0;
        while (!m_tvalid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rst_pkt_started", 128'(m_tvalid), 128'(1'b1));
        @(posedge clk);
        #2;
        check("rst_beat2_tdata", 128'(m_tdata), 128'(64'h0000_0066_0000_0001));
        rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", 128'(m_tvalid), 128'(1'b0));
        check("mid_rst_tdata", 128'(m_tdata), 128'(0));
        check("mid_rst_drop_count", 128'(drop_count), 128'(0));
        check("mid_rst_s_tready", 128'(s_tready), 128'(1'b0));
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_pkt(2, 128'h77, 1'b1, stalls);
        wait_drain("post_rst_drain");
        check("post_rst_drop_count", 128'(drop_count), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
